// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the clock display blocks.
// Patterns are active-low and packed {g,f,e,d,c,b,a}: a cleared bit lights
// that segment on the common-anode display.
// Contents: segment bus width, blank pattern, digit glyphs SEG_0..SEG_9,
// segment bit-order enum and an index-width helper.
package seg_pkg;

  localparam int SEG_W = 7;

  // Bit position of each segment inside a pattern
  typedef enum int {
    SEG_BIT_A = 0,
    SEG_BIT_B = 1,
    SEG_BIT_C = 2,
    SEG_BIT_D = 3,
    SEG_BIT_E = 4,
    SEG_BIT_F = 5,
    SEG_BIT_G = 6
  } seg_bit_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

  // Width of a counter indexing n items; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer for the display scanner.
// Counts div through each digit slot and idx through the digits, holding
// both while en is low. Exposes the next-state div/idx so the caller can
// register outputs that describe the same state the timer moves into.
// Ports:
//   clk, glob_rst  clock and asynchronous active-high reset
//   en             advance enable; 0 holds div/idx
//   div_nxt        div value after this edge
//   idx_nxt        idx value after this edge
//   frame_done     registered pulse, high while state is (0,0) after a wrap
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int N_DIG    = 6,
  parameter int SCAN_DIV = 4,
  parameter int IDX_W    = idx_width(N_DIG),
  parameter int DIV_W    = idx_width(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             glob_rst,
  input  logic             en,
  output logic [DIV_W-1:0] div_nxt,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             frame_done
);

  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic             frame_wrap;

  // Next-state: div runs 0..SCAN_DIV-1, idx steps once per div wrap and
  // itself wraps after the last digit; that double wrap marks a new frame
  always_comb begin
    div_nxt    = div;
    idx_nxt    = idx;
    frame_wrap = 1'b0;
    if (en) begin
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div_nxt = '0;
        if (idx == IDX_W'(N_DIG - 1)) begin
          idx_nxt    = '0;
          frame_wrap = 1'b1;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end else begin
        div_nxt = div + DIV_W'(1);
      end
    end
  end

  // State register; frame_done is registered alongside the state it flags,
  // so the (0,0) state reached from reset never raises it
  always_ff @(posedge clk or posedge glob_rst) begin
    if (glob_rst) begin
      div        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      div        <= div_nxt;
      idx        <= idx_nxt;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: rtl/seg_scan_drv.sv
// Seven-segment scan driver for the six-digit clock display.
// Multiplexes per-digit active-low patterns onto one segment bus with
// one-hot active-low digit enables, a blank guard at the start of each
// slot to stop ghosting, and per-digit blinking.
// Ports:
//   clk, glob_rst  clock and asynchronous active-high reset
//   en             scan enable; 0 freezes the scan and blanks the display
//   seg_in         digit patterns, digit k at [7k+6:7k]
//   blink_mask     digits taking part in blinking
//   blink_tick     one-cycle pulse toggling the blink phase
//   seg_out        shared segment bus (active-low)
//   dig_en_n       digit enables (active-low, at most one low)
//   dig_idx        index of the current slot
//   frame_done     one-cycle pulse at the start of each frame
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int N_DIG       = 6,
  parameter int SCAN_DIV    = 4,
  parameter int BLANK_GUARD = 1,
  parameter int IDX_W       = idx_width(N_DIG)
) (
  input  logic                   clk,
  input  logic                   glob_rst,
  input  logic                   en,
  input  logic [SEG_W*N_DIG-1:0] seg_in,
  input  logic [N_DIG-1:0]       blink_mask,
  input  logic                   blink_tick,
  output logic [SEG_W-1:0]       seg_out,
  output logic [N_DIG-1:0]       dig_en_n,
  output logic [IDX_W-1:0]       dig_idx,
  output logic                   frame_done
);

  localparam int DIV_W = idx_width(SCAN_DIV);

  logic [DIV_W-1:0] div_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             blink_phase;
  logic             phase_nxt;
  logic [SEG_W-1:0] seg_d;
  logic [N_DIG-1:0] dig_en_d;

  seg_slot_timer #(
    .N_DIG    (N_DIG),
    .SCAN_DIV (SCAN_DIV),
    .IDX_W    (IDX_W),
    .DIV_W    (DIV_W)
  ) u_timer (
    .clk        (clk),
    .glob_rst   (glob_rst),
    .en         (en),
    .div_nxt    (div_nxt),
    .idx_nxt    (idx_nxt),
    .frame_done (frame_done)
  );

  // A tick flips the phase on the edge it is sampled, and that same edge
  // already decodes with the new phase
  assign phase_nxt = blink_phase ^ blink_tick;

  // Blink phase register, running regardless of scan enable
  always_ff @(posedge clk or posedge glob_rst) begin
    if (glob_rst) begin
      blink_phase <= 1'b0;
    end else begin
      blink_phase <= phase_nxt;
    end
  end

  // Decode from the state being entered: blank while disabled, in the guard
  // cycles, or when the digit is blinked dark; otherwise light one digit.
  // The signed compare keeps BLANK_GUARD=0 from becoming a constant test.
  always_comb begin
    seg_d    = SEG_BLANK;
    dig_en_d = '1;
    if (en && (int'(div_nxt) >= BLANK_GUARD) &&
        !(blink_mask[idx_nxt] && phase_nxt)) begin
      seg_d             = seg_in[SEG_W*idx_nxt +: SEG_W];
      dig_en_d[idx_nxt] = 1'b0;
    end
  end

  // Output registers, loaded on the same edge as the timer state
  always_ff @(posedge clk or posedge glob_rst) begin
    if (glob_rst) begin
      seg_out  <= SEG_BLANK;
      dig_en_n <= '1;
      dig_idx  <= '0;
    end else begin
      seg_out  <= seg_d;
      dig_en_n <= dig_en_d;
      dig_idx  <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv: two instances (6 digits/4 cycles/guard 1 and
// 3 digits/2 cycles/no guard) share one stimulus stream. A reference model
// tracks elapsed scan cycles and predicts each edge; predictions go into a
// queue that a monitor drains on the falling edge.
module tb_seg_scan_drv;
  import seg_pkg::*;

  localparam int NA = 6, DA = 4, GA = 1;
  localparam int NB = 3, DB = 2, GB = 0;

  typedef struct {
    logic [6:0] sa; logic [5:0] ea; int ia; bit fa;
    logic [6:0] sb; logic [5:0] eb; int ib; bit fb;
  } exp_t;

  logic        clk = 1'b0;
  logic        glob_rst;
  logic        en;
  logic [41:0] seg_in;
  logic [5:0]  blink_mask;
  logic        blink_tick;

  logic [6:0] seg_out_a, seg_out_b;
  logic [5:0] dig_en_n_a;
  logic [2:0] dig_en_n_b;
  logic [2:0] dig_idx_a;
  logic [1:0] dig_idx_b;
  logic       frame_done_a, frame_done_b;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   cnt_a, cnt_b;
  bit   phase;

  seg_scan_drv #(.N_DIG(NA), .SCAN_DIV(DA), .BLANK_GUARD(GA)) dut_a (
    .clk(clk), .glob_rst(glob_rst), .en(en), .seg_in(seg_in),
    .blink_mask(blink_mask), .blink_tick(blink_tick), .seg_out(seg_out_a),
    .dig_en_n(dig_en_n_a), .dig_idx(dig_idx_a), .frame_done(frame_done_a)
  );

  seg_scan_drv #(.N_DIG(NB), .SCAN_DIV(DB), .BLANK_GUARD(GB)) dut_b (
    .clk(clk), .glob_rst(glob_rst), .en(en), .seg_in(seg_in[20:0]),
    .blink_mask(blink_mask[2:0]), .blink_tick(blink_tick), .seg_out(seg_out_b),
    .dig_en_n(dig_en_n_b), .dig_idx(dig_idx_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Prediction for a display of n digits, d cycles per slot, g guard cycles,
  // cnt = scan cycles elapsed within the current frame after this edge
  function automatic void predict(input int n, input int d, input int g, input int cnt,
                                  input bit ph, input bit enb, input logic [41:0] segs,
                                  input logic [5:0] mask, output logic [6:0] s,
                                  output logic [5:0] e, output int ix, output bit fd);
    int slot, off;
    slot = cnt / d;
    off  = cnt % d;
    ix   = slot;
    s    = 7'h7F;
    e    = 6'((1 << n) - 1);
    fd   = 1'b0;
    if (enb) begin
      fd = (cnt == 0);
      if (off >= g && !(mask[slot] && ph)) begin
        s       = segs[7*slot +: 7];
        e[slot] = 1'b0;
      end
    end
  endfunction

  // Reference model: advances on every clock, cleared by reset at once
  always @(posedge clk or posedge glob_rst) begin
    exp_t x;
    if (glob_rst) begin
      cnt_a = 0;
      cnt_b = 0;
      phase = 1'b0;
      exp_q.delete();
    end else begin
      phase = phase ^ blink_tick;
      if (en) begin
        cnt_a = (cnt_a + 1) % (NA * DA);
        cnt_b = (cnt_b + 1) % (NB * DB);
      end
      predict(NA, DA, GA, cnt_a, phase, en, seg_in, blink_mask, x.sa, x.ea, x.ia, x.fa);
      predict(NB, DB, GB, cnt_b, phase, en, seg_in, blink_mask, x.sb, x.eb, x.ib, x.fb);
      exp_q.push_back(x);
    end
  end

  // Monitor: reset values while in reset, otherwise the queued prediction
  always @(negedge clk) begin
    exp_t x;
    if (glob_rst) begin
      checkOutput("rst_seg_a", seg_out_a, 7'h7F);
      checkOutput("rst_en_a", dig_en_n_a, 6'h3F);
      checkOutput("rst_idx_a", dig_idx_a, 0);
      checkOutput("rst_fd_a", frame_done_a, 0);
      checkOutput("rst_en_b", dig_en_n_b, 3'h7);
    end else begin
      checkOutput("onehot_a", $countones(~dig_en_n_a) <= 1, 1);
      checkOutput("onehot_b", $countones(~dig_en_n_b) <= 1, 1);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("seg_a", seg_out_a, x.sa);
        checkOutput("en_a", dig_en_n_a, x.ea);
        checkOutput("idx_a", dig_idx_a, x.ia);
        checkOutput("fd_a", frame_done_a, x.fa);
        checkOutput("seg_b", seg_out_b, x.sb);
        checkOutput("en_b", {3'b000, dig_en_n_b}, x.eb);
        checkOutput("idx_b", dig_idx_b, x.ib);
        checkOutput("fd_b", frame_done_b, x.fb);
      end
    end
  end

  // Advance n cycles, driving inputs 2 time units after each rising edge;
  // rnd picks randomized traffic, otherwise inputs hold and ticks clear
  task automatic applyStimulus(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #2;
      blink_tick = 1'b0;
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) begin
          int k;
          k = $urandom_range(0, 5);
          seg_in[7*k +: 7] = 7'($urandom);
        end
        en         = ($urandom_range(0, 15) != 0);
        blink_tick = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 63) == 0) blink_mask = 6'($urandom);
      end
    end
  endtask

  initial begin
    glob_rst   = 1'b1;
    en         = 1'b0;
    seg_in     = {SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
    blink_mask = '0;
    blink_tick = 1'b0;
    applyStimulus(3, 0);

    $display("[TB] basic scan");
    glob_rst = 1'b0;
    en       = 1'b1;
    applyStimulus(60, 0);

    $display("[TB] blink");
    blink_mask = 6'b000011;
    blink_tick = 1'b1;
    applyStimulus(30, 0);
    blink_tick = 1'b1;
    applyStimulus(30, 0);

    $display("[TB] enable freeze at digit 3 div 2");
    for (int k = 0; k < 48 && cnt_a != 14; k++) applyStimulus(1, 0);
    en = 1'b0;
    applyStimulus(10, 0);
    en = 1'b1;
    applyStimulus(12, 0);

    $display("[TB] live update of digit 2");
    seg_in[14 +: 7] = SEG_8;
    for (int k = 0; k < 48 && cnt_a != 9; k++) applyStimulus(1, 0);
    seg_in[14 +: 7] = SEG_1;
    applyStimulus(10, 0);

    $display("[TB] async reset mid-frame");
    for (int k = 0; k < 48 && (cnt_a / DA) != 4; k++) applyStimulus(1, 0);
    glob_rst = 1'b1;
    #1;
    checkOutput("async_seg_a", seg_out_a, 7'h7F);
    checkOutput("async_en_a", dig_en_n_a, 6'h3F);
    checkOutput("async_idx_a", dig_idx_a, 0);
    checkOutput("async_seg_b", seg_out_b, 7'h7F);
    checkOutput("async_en_b", dig_en_n_b, 3'h7);
    #1;
    glob_rst = 1'b0;
    applyStimulus(40, 0);

    $display("[TB] randomized traffic");
    applyStimulus(2000, 1);
    en = 1'b1;
    applyStimulus(5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
